// File: rtl/mmss_countdown_timer_pkg.sv
// Shared definitions for the MM:SS timer: BCD digit layout, digit moduli, count mode.
// Also provides a compare-ladder binary-to-BCD helper for minute presets up to 99.
package mmss_countdown_timer_pkg;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } mode_e;

  localparam int DIGIT_W   = 4;
  localparam int TIMER_W   = 4 * DIGIT_W;
  localparam int SEC1_MOD  = 10;
  localparam int SEC10_MOD = 6;
  localparam int MIN_MOD   = 10;

  // Field offsets inside timer = {min10, min1, sec10, sec1}
  localparam int SEC1_LSB  = 0;
  localparam int SEC10_LSB = 4;
  localparam int MIN1_LSB  = 8;
  localparam int MIN10_LSB = 12;

  // Tens digit picked by the highest threshold passed; no divider needed
  function automatic logic [2*DIGIT_W-1:0] bin2bcd(input logic [6:0] v);
    logic [DIGIT_W-1:0] tens;
    logic [6:0]         rem;
    tens = '0;
    rem  = v;
    for (int i = 9; i >= 1; i--) begin
      if (tens == '0 && v >= 7'(i * 10)) begin
        tens = DIGIT_W'(i);
        rem  = v - 7'(i * 10);
      end
    end
    return {tens, DIGIT_W'(rem)};
  endfunction

endpackage

// File: rtl/mmss_countdown_timer_if.sv
// Control and status bundle of the MM:SS timer.
// master drives load/preset/mode_up/run; slave (the timer) returns time and status.
interface mmss_countdown_timer_if #(
  parameter int PRESET_W = 7
);
  logic                load;
  logic [PRESET_W-1:0] preset;
  logic                mode_up;
  logic                run;
  logic [15:0]         timer;
  logic                running;
  logic                done;
  logic                expired;

  modport master (
    output load, preset, mode_up, run,
    input  timer, running, done, expired
  );

  modport slave (
    input  load, preset, mode_up, run,
    output timer, running, done, expired
  );
endinterface

// File: rtl/mmss_countdown_timer_bcd_digit_ctr.sv
// One BCD digit with modulus MOD: load has priority, then inc or dec with carry/borrow out.
// nxt exposes the value the digit will take on the next edge.
module mmss_countdown_timer_bcd_digit_ctr
  import mmss_countdown_timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] q,
  output logic [DIGIT_W-1:0] nxt,
  output logic               co,
  output logic               bo
);

  assign co = inc & (q == DIGIT_W'(MOD - 1));
  assign bo = dec & (q == '0);

  always_comb begin
    nxt = q;
    if (ld) begin
      nxt = ld_val;
    end else if (inc) begin
      nxt = co ? '0 : q + 1'b1;
    end else if (dec) begin
      nxt = bo ? DIGIT_W'(MOD - 1) : q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/mmss_countdown_timer.sv
// MM:SS countdown / count-up timer with second prescaler, pause, done pulse and sticky expiry.
// All outputs are registered; load takes priority over a coincident tick.
module mmss_countdown_timer
  import mmss_countdown_timer_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int PRESET_W = 7,
  parameter int MAX_MIN  = 99
) (
  input  logic                 clk,
  input  logic                 rstn,
  mmss_countdown_timer_if.slave tif
);

  localparam int PW = $clog2(CLK_HZ);

  logic [PW-1:0]      presc;
  mode_e              mode;
  logic [TIMER_W-1:0] target;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_nxt;
  logic               done_q;
  logic               expired_q;
  logic               running_q;

  logic [31:0]        pre_ext;
  logic [6:0]         pm;
  logic [7:0]         pm_bcd;
  logic [TIMER_W-1:0] ld_timer;
  logic [TIMER_W-1:0] ld_target;
  logic               cnt_en;
  logic               tick;
  logic               step;
  logic               term;
  logic               exp_nxt;
  logic [4:0]         cy;
  logic [4:0]         bw;
  logic               unused_carry;

  assign pre_ext   = 32'(tif.preset);
  assign pm        = (pre_ext > 32'(MAX_MIN)) ? 7'(MAX_MIN) : 7'(pre_ext);
  assign pm_bcd    = bin2bcd(pm);
  assign ld_timer  = tif.mode_up ? '0 : {pm_bcd, 8'h00};
  assign ld_target = tif.mode_up ? {pm_bcd, 8'h00} : '0;

  // Expiry freezes the prescaler as well as the digits
  assign cnt_en  = tif.run & ~expired_q;
  assign tick    = cnt_en & (presc == PW'(CLK_HZ - 1));
  assign step    = tick & ~tif.load;
  assign term    = step & (timer_nxt == target);
  assign exp_nxt = tif.load ? (pm == '0) : (expired_q | term);

  assign cy[0] = step & (mode == MODE_UP);
  assign bw[0] = step & (mode == MODE_DOWN);

  for (genvar g = 0; g < 4; g++) begin : g_digit
    localparam int DMOD = (g == 0) ? SEC1_MOD : (g == 1) ? SEC10_MOD : MIN_MOD;
    mmss_countdown_timer_bcd_digit_ctr #(.MOD(DMOD)) u_digit (
      .clk    (clk),
      .rstn   (rstn),
      .ld     (tif.load),
      .ld_val (ld_timer[g*DIGIT_W +: DIGIT_W]),
      .inc    (cy[g]),
      .dec    (bw[g]),
      .q      (timer_q[g*DIGIT_W +: DIGIT_W]),
      .nxt    (timer_nxt[g*DIGIT_W +: DIGIT_W]),
      .co     (cy[g+1]),
      .bo     (bw[g+1])
    );
  end

  // Terminal detection stops the count before min10 could ever wrap
  assign unused_carry = cy[4] | bw[4];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc     <= '0;
      mode      <= MODE_DOWN;
      target    <= '0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      if (tif.load) begin
        presc     <= '0;
        mode      <= mode_e'(tif.mode_up);
        target    <= ld_target;
        done_q    <= 1'b0;
        expired_q <= (pm == '0);
      end else begin
        if (cnt_en) begin
          presc <= tick ? '0 : presc + 1'b1;
        end
        done_q <= term;
        if (term) begin
          expired_q <= 1'b1;
        end
      end
      running_q <= tif.run & ~exp_nxt;
    end
  end

  assign tif.timer   = timer_q;
  assign tif.done    = done_q;
  assign tif.expired = expired_q;
  assign tif.running = running_q;

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Directed plus randomized bench for mmss_countdown_timer (CLK_HZ=10), checked against
// a seconds-based reference model of the timer.
module tb_mmss_countdown_timer;

  localparam int CLK_HZ = 10;

  logic clk;
  logic rstn;

  mmss_countdown_timer_if #(.PRESET_W(7)) tif ();

  mmss_countdown_timer #(.CLK_HZ(CLK_HZ), .PRESET_W(7), .MAX_MIN(99)) dut (
    .clk  (clk),
    .rstn (rstn),
    .tif  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;

  // Reference model: time kept as a plain number of seconds
  int m_cur, m_tgt, m_ph;
  bit m_up, m_done, m_exp, m_run;
  int dut_done_n, mdl_done_n;

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_ph = 0;
    m_up = 0; m_done = 0; m_exp = 0; m_run = 0;
  endtask

  task automatic model_step(input bit ld, input int pre, input bit mu, input bit rn);
    int pm;
    if (ld) begin
      pm     = (pre > 99) ? 99 : pre;
      m_up   = mu;
      m_cur  = mu ? 0 : pm * 60;
      m_tgt  = mu ? pm * 60 : 0;
      m_ph   = 0;
      m_done = 0;
      m_exp  = (pm == 0);
    end else begin
      m_done = 0;
      if (rn && !m_exp) begin
        if (m_ph == CLK_HZ - 1) begin
          m_ph  = 0;
          m_cur = m_up ? m_cur + 1 : m_cur - 1;
          if (m_cur == m_tgt) begin
            m_done = 1;
            m_exp  = 1;
          end
        end else begin
          m_ph++;
        end
      end
    end
    m_run = rn && !m_exp;
    if (m_done) mdl_done_n++;
  endtask

  // One clock: capture inputs seen at the edge, advance the model, settle
  task automatic cyc();
    bit ld, mu, rn, rs;
    int pre;
    ld = tif.load; mu = tif.mode_up; rn = tif.run; pre = int'(tif.preset); rs = rstn;
    @(posedge clk);
    if (!rs) model_reset();
    else     model_step(ld, pre, mu, rn);
    #1;
    if (tif.done === 1'b1) dut_done_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".timer"},   32'(tif.timer),   32'(to_bcd(m_cur)));
    chk({tag, ".done"},    32'(tif.done),    32'(m_done));
    chk({tag, ".expired"}, 32'(tif.expired), 32'(m_exp));
    chk({tag, ".running"}, 32'(tif.running), 32'(m_run));
  endtask

  task automatic do_load(input int pre, input bit mu);
    tif.load = 1'b1; tif.preset = 7'(pre); tif.mode_up = mu;
    cyc();
    tif.load = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    tif.load = 1'b0; tif.preset = '0; tif.mode_up = 1'b0; tif.run = 1'b0;
    model_reset();
    dut_done_n = 0; mdl_done_n = 0;
    #12;
    chk("rst_timer", 32'(tif.timer), 32'h0);
    rstn = 1'b1;

    // 1: idle after reset
    repeat (50) cyc();
    chk_all("idle");
    chk("idle_timer_const", 32'(tif.timer), 32'h0000);

    // 2: two-minute countdown
    dut_done_n = 0; mdl_done_n = 0;
    tif.run = 1'b1;
    do_load(2, 1'b0);
    repeat (10) cyc();
    chk_all("down10");
    chk("down10_const", 32'(tif.timer), 32'h0159);
    repeat (1190) cyc();
    chk_all("down_end");
    chk("down_end_const", 32'(tif.timer), 32'h0000);
    chk("down_end_pulses", 32'(dut_done_n), 32'd1);
    repeat (100) cyc();
    chk_all("down_hold");
    chk("down_hold_pulses", 32'(dut_done_n), 32'(mdl_done_n));

    // 3: pause preserves sub-second phase
    do_load(5, 1'b0);
    repeat (4) cyc();
    tif.run = 1'b0;
    repeat (37) cyc();
    chk_all("pause");
    chk("pause_const", 32'(tif.timer), 32'h0500);
    tif.run = 1'b1;
    repeat (5) cyc();
    chk("resume5_const", 32'(tif.timer), 32'h0500);
    cyc();
    chk_all("resume6");
    chk("resume6_const", 32'(tif.timer), 32'h0459);

    // 4: count up to one minute
    dut_done_n = 0; mdl_done_n = 0;
    do_load(1, 1'b1);
    repeat (590) cyc();
    chk("up590_const", 32'(tif.timer), 32'h0059);
    repeat (10) cyc();
    chk_all("up600");
    chk("up600_const", 32'(tif.timer), 32'h0100);
    chk("up600_done", 32'(tif.done), 32'd1);
    cyc();
    chk("up601_done", 32'(tif.done), 32'd0);
    chk("up601_expired", 32'(tif.expired), 32'd1);

    // 5: load coinciding with a tick, saturated preset
    do_load(3, 1'b0);
    repeat (9) cyc();
    do_load(120, 1'b0);
    chk_all("ld_tick");
    chk("ld_tick_const", 32'(tif.timer), 32'h9900);
    repeat (10) cyc();
    chk_all("ld_tick_next");
    chk("ld_tick_next_const", 32'(tif.timer), 32'h9859);

    // 6: zero preset, then asynchronous reset mid-count
    dut_done_n = 0; mdl_done_n = 0;
    do_load(0, 1'b0);
    chk_all("zero_ld");
    repeat (50) cyc();
    chk("zero_pulses", 32'(dut_done_n), 32'd0);
    chk("zero_expired", 32'(tif.expired), 32'd1);
    do_load(3, 1'b0);
    repeat (25) cyc();
    chk("pre_rst_timer", 32'(tif.timer), 32'h0258);
    rstn = 1'b0;
    #1;
    chk("async_rst_timer", 32'(tif.timer), 32'h0000);
    chk("async_rst_done", 32'(tif.done), 32'd0);
    chk("async_rst_running", 32'(tif.running), 32'd0);
    model_reset();
    cyc();
    rstn = 1'b1;
    cyc();
    chk_all("post_rst");

    // Randomized: sporadic loads, run toggling, preset/mode churn without load
    tif.run = 1'b1;
    do_load(1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      tif.preset  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                : 7'($urandom_range(0, 2));
      tif.mode_up = 1'($urandom_range(0, 1));
      tif.load    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) tif.run = ~tif.run;
      cyc();
      chk_all("rand");
    end
    chk("rand_pulses", 32'(dut_done_n), 32'(mdl_done_n));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
